// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract unit.
// Processes one CHUNK-bit slice of a WIDTH-bit operand pair per clock and
// carries between slices through a register, so the combinational carry
// chain is only CHUNK bits long.
// Optional feature macro: SEQ_CHUNK_ADDER_OVF_EN adds the signed overflow
// output 'ovf'. In the default build the port and its logic are absent.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE and out_valid is 1 only in DONE. Once
// out_valid is raised, sum/cout (and ovf) stay stable until out_ready is seen.
// in_valid is ignored while in_ready is 0.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Reject illegal parameter combinations at elaboration.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("seq_chunk_adder: WIDTH must be >= 1");
    end
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [31:0]      off;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] s_sl;
  logic             c_sl;
  logic             last;
  logic             accept;

  assign accept    = in_valid && (state == S_IDLE);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  // Bit offset of the slice currently being processed.
  assign off  = 32'(idx) * 32'(CHUNK);
  assign last = (idx == IDXW'(NCHUNK - 1));

  // One slice of the addition, one bit wider than CHUNK to capture the carry.
  always_comb begin
    a_sl = a_r[off +: CHUNK];
    b_sl = b_r[off +: CHUNK];
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
  end

  // Operand capture. Subtraction is folded in here as A + ~B + ~cin, so the
  // slice datapath is always a plain adder.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      a_r <= a;
      b_r <= b ^ {WIDTH{sub}};
    end
  end

  // Control FSM plus slice counter, carry, and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            idx   <= '0;
            carry <= cin ^ sub;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[off +: CHUNK] <= s_sl;
          carry             <= c_sl;
          if (last) begin
            // Park idx at 0 so it never points outside the operand.
            idx   <= '0;
            cout  <= c_sl;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            // a^b^s at the top bit recovers the carry into that bit.
            ovf   <= a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1] ^ c_sl;
`endif
            state <= S_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed and random checks of seq_chunk_adder.
// Three instances share clk/rst: CHUNK=4 (index 0), CHUNK=16 (index 1) and
// CHUNK=1 (index 2), all with WIDTH=16. Expected results are pushed to a
// queue when an operation is issued and popped when the DUT presents it.
// Define SEQ_CHUNK_ADDER_OVF_EN for both files to also check ovf.
module tb_seq_chunk_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         cin       [3];
  logic         sub       [3];
  logic         cout      [3];
  logic [W-1:0] a         [3];
  logic [W-1:0] b         [3];
  logic [W-1:0] sum       [3];
  logic [1:0]   dbg       [3];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic         ovf       [3];
`endif

  int errors = 0;
  int checks = 0;

  // Entries are {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .cout(cout[0]),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    .ovf(ovf[0]),
`endif
    .dbg_state(dbg[0])
  );

  seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .cout(cout[1]),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    .ovf(ovf[1]),
`endif
    .dbg_state(dbg[1])
  );

  seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum[2]), .cout(cout[2]),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    .ovf(ovf[2]),
`endif
    .dbg_state(dbg[2])
  );

  // Reference model: plain integer add or subtract with borrow, cout as
  // carry / no-borrow, ovf from operand and result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    logic [W:0] r;
    logic       co;
    logic       v;
    if (ms) begin
      r  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
      co = ~r[W];
      v  = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    end else begin
      r  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      co = r[W];
      v  = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    end
    return {v, co, r[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Compare presented result against the expectation at the queue head.
  task automatic check_result(input int k, input string tag, input logic [W+1:0] e);
    check({tag, "_sum"}, 32'(sum[k]), 32'(e[W-1:0]));
    check({tag, "_cout"}, 32'(cout[k]), 32'(e[W]));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf[k]), 32'(e[W+1]));
`endif
  endtask

  // Issue one operation on instance k (called at a falling edge), measure
  // latency, optionally hold out_ready low for 'hold' cycles while pulsing
  // in_valid, then consume the result.
  task automatic run_op(input int k, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub, input int exp_lat,
                        input int hold, input string tag);
    logic [W+1:0] e;
    int cnt;
    check({tag, "_in_ready_idle"}, 32'(in_ready[k]), 32'd1);
    a[k] = ta; b[k] = tb; cin[k] = tcin; sub[k] = tsub;
    in_valid[k]  = 1'b1;
    out_ready[k] = (hold == 0);
    exp_q.push_back(model(ta, tb, tcin, tsub));
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    a[k] = 16'($urandom_range(0, 16'hFFFF));
    b[k] = 16'($urandom_range(0, 16'hFFFF));
    cin[k] = 1'($urandom_range(0, 1));
    sub[k] = 1'($urandom_range(0, 1));
    while (!out_valid[k] && cnt < 40) begin
      check({tag, "_in_ready_run"}, 32'(in_ready[k]), 32'd0);
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    if (!out_valid[k]) begin
      check({tag, "_timeout"}, 32'(out_valid[k]), 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(out_valid[k]), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(in_ready[k]), 32'd0);
      check_result(k, {tag, "_hold"}, e);
      in_valid[k] = (i % 2 == 0);
      a[k] = 16'($urandom_range(0, 16'hFFFF));
      b[k] = 16'($urandom_range(0, 16'hFFFF));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid[k] = 1'b0;
    e = exp_q.pop_front();
    check_result(k, tag, e);
    out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_valid"}, 32'(out_valid[k]), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready[k]), 32'd1);
    check({tag, "_sum_kept"}, 32'(sum[k]), 32'(e[W-1:0]));
    out_ready[k] = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      a[k] = '0; b[k] = '0; cin[k] = 1'b0; sub[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_in_ready", k), 32'(in_ready[k]), 32'd1);
      check($sformatf("rst%0d_out_valid", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("rst%0d_sum", k), 32'(sum[k]), 32'd0);
      check($sformatf("rst%0d_cout", k), 32'(cout[k]), 32'd0);
    end

    // Basic add, full carry ripple, subtract both ways, signed overflow
    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 5, 0, "t1");
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 5, 0, "t2");
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 5, 0, "t3a");
    run_op(0, 16'h0007, 16'h0005, 1'b1, 1'b1, 5, 0, "t3b");
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 5, 0, "t4a");
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 5, 0, "t4b");

    // Backpressure in DONE, then a normal follow-up operation
    run_op(0, 16'hABCD, 16'h1357, 1'b1, 1'b0, 5, 10, "t5_bp");
    run_op(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 5, 0, "t5_next");

    // Reset during the second RUN slice discards the operation
    a[0] = 16'hFFFF; b[0] = 16'h0001; cin[0] = 1'b0; sub[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_in_run", 32'(in_ready[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_out_valid", 32'(out_valid[0]), 32'd0);
    check("t6_in_ready", 32'(in_ready[0]), 32'd1);
    check("t6_sum", 32'(sum[0]), 32'd0);
    check("t6_cout", 32'(cout[0]), 32'd0);
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 5, 0, "t6_after");

    // Random operands on the CHUNK=4 instance
    for (int i = 0; i < 6; i++) begin
      run_op(0, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5, i % 3,
             $sformatf("rnd%0d", i));
    end

    // Latency with CHUNK=WIDTH and CHUNK=1
    run_op(1, 16'h1234, 16'h1111, 1'b0, 1'b0, 2, 0, "c16_t1");
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 2, 0, "c16_t2");
    run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 2, 2, "c16_t4b");
    run_op(2, 16'h1234, 16'h1111, 1'b0, 1'b0, 17, 0, "c1_t1");
    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17, 0, "c1_t2");
    run_op(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 17, 3, "c1_t3a");
    run_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17, 0, "c1_t4a");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
